intersection_scheduler: RTL
===========================

# intersection_scheduler

Four-approach intersection phase scheduler that shares the right-of-way among approaches with vehicle detectors and a latched pedestrian button. It generates one-hot Red/Yellow/Green lamp drives per approach and a walk signal, enforcing minimum and maximum green, yellow change and all-red clearance intervals. It sits above the per-lamp drivers and replaces fixed-cycle sequencing with demand-driven round-robin arbitration.

## Interface
- T_GMIN, 3: minimum green, in ticks (≥1)
- T_GMAX, 6: maximum green under conflicting demand, in ticks (≥T_GMIN)
- T_Y, 2: yellow interval, in ticks (≥1)
- T_AR, 1: all-red clearance, in ticks (≥1)
- T_WALK, 4: pedestrian walk interval, in ticks (≥1)
- CW, 4: timer width; must hold max(all T)-1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-cycle timebase enable; all timing counts ticks only
- req  in  4  vehicle demand level per approach, already synchronous to clk
- ped_req  in  1  pedestrian button pulse, synchronous to clk
- lights  out  12  approach i lamps at [3i+2:3i]; Red=001, Yellow=010, Green=100
- walk  out  1  pedestrian walk lamp
- cur  out  2  currently/last granted approach

## Operation
- States: ALLRED, GREEN, YELLOW, WALK. Timer cnt cleared on every state entry; increments on tick; state T lasts exactly T ticks (exit on tick with cnt==T-1).
- Reset: state=ALLRED, cnt=0, cur=0, ped_pending=0, lights=0x249 (all red), walk=0.
- demand = ped_pending OR any req[j] with j≠cur.
- GREEN (approach cur green, others red): on a tick with cnt≥T_GMIN-1 and demand and req[cur]=0 → YELLOW. On a tick with cnt==T_GMAX-1 and demand → YELLOW regardless of req[cur]. No demand: stay GREEN indefinitely; cnt saturates at T_GMAX-1.
- YELLOW (cur yellow, others red): after T_Y ticks → ALLRED.
- ALLRED (all red): after T_AR ticks: if ped_pending → WALK; else grant first j with req[j]=1 searching cur+1, cur+2, cur+3, cur (mod 4); none requesting → cur keeps grant. Load cur, → GREEN.
- WALK (all red, walk=1): ped_pending cleared on entry; after T_WALK ticks → ALLRED (cur unchanged, so round-robin resumes after it).
- ped_pending set by ped_req in any state except WALK; ped_req during WALK ignored. Set has priority over nothing else; cleared only on WALK entry or reset.
- Never two approaches non-red simultaneously; walk=1 only when all lamps red.

## Timing
- lights, walk, cur are registered Moore outputs; they change on the same clk edge as the state register (edge on which the terminating tick is sampled).
- tick=0 freezes cnt and state; req/ped_req still sampled (ped_pending still latches).
- ped_req and a state-exiting tick in the same cycle: latch counts for the ALLRED decision if ALLRED exits on a later edge; ped_req coincident with the ALLRED exit edge is not seen by that decision (served next cycle round).
- req changes are sampled only on tick edges for transitions; single-cycle req pulses between ticks are ignored.
- rst mid-operation: immediate return to reset values, including cur=0 and ped_pending=0.

## Test plan
- Reset, tick every cycle, req=0 → lights=0x249 for 1 tick, then approach 0 green, lights=0x24C, held indefinitely, cur=0.
- From approach 0 green (cnt=0), req=0100 → green 3 ticks, lights=0x24A for 2 ticks, 0x249 for 1 tick, then lights=0x309, cur=2.
- req=0011 held from approach 0 green → green 6 ticks (max), yellow 2, all-red 1, then approach 1 green (lights=0x261), cur=1.
- Approach 1 green, req=1000, ped_req pulse → yellow, all-red, walk=1 with 0x249 for 4 ticks, all-red 1, then approach 3 green (lights=0x849), cur=3; ped_req during walk produces no second walk.
- tick held 0 for 10 cycles mid-YELLOW → lights unchanged; resumes remaining yellow ticks exactly.
- rst asserted mid-WALK with ped_pending re-pressed → same cycle lights=0x249, walk=0, cur=0; after release no WALK occurs.

Source files
------------

// File: rtl/intersection_scheduler.sv
// intersection_scheduler
//   Demand-driven phase scheduler for a four-approach intersection with a
//   latched pedestrian button. Approaches take turns in round-robin order;
//   each green is bounded by minimum/maximum timers and is followed by a
//   yellow change interval and an all-red clearance interval. A pending
//   pedestrian request is served with an all-red walk phase between greens.
//
// Ports
//   clk      in   clock
//   rst      in   asynchronous, active-high reset
//   tick     in   one-cycle timebase enable; all intervals count ticks
//   req      in   [3:0] vehicle demand level per approach
//   ped_req  in   pedestrian button pulse
//   lights   out  [11:0] approach i lamps at [3i+2:3i]; R=001 Y=010 G=100
//   walk     out  pedestrian walk lamp
//   cur      out  [1:0] currently / last granted approach
module intersection_scheduler #(
  parameter int unsigned T_GMIN = 3,
  parameter int unsigned T_GMAX = 6,
  parameter int unsigned T_Y    = 2,
  parameter int unsigned T_AR   = 1,
  parameter int unsigned T_WALK = 4,
  parameter int unsigned CW     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [3:0]  req,
  input  logic        ped_req,
  output logic [11:0] lights,
  output logic        walk,
  output logic [1:0]  cur
);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_WALK   = 2'd3
  } state_t;

  // Terminal counts: a state lasting T ticks exits on the tick with cnt==T-1.
  localparam logic [CW-1:0] L_GMIN = CW'(T_GMIN - 1);
  localparam logic [CW-1:0] L_GMAX = CW'(T_GMAX - 1);
  localparam logic [CW-1:0] L_Y    = CW'(T_Y - 1);
  localparam logic [CW-1:0] L_AR   = CW'(T_AR - 1);
  localparam logic [CW-1:0] L_WALK = CW'(T_WALK - 1);

  localparam logic [11:0] ALL_RED = 12'h249;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_cur;
  logic          r_ped_pending;
  logic [11:0]   r_lights;
  logic          r_walk;

  state_t        w_nstate;
  logic [CW-1:0] w_ncnt;
  logic [1:0]    w_ncur;
  logic          w_nped;
  logic          w_demand;
  logic [1:0]    w_grant;
  logic [3:0]    w_cur_mask;

  // Lamp pattern for a given phase and approach.
  function automatic logic [11:0] lamp_pattern(input state_t s, input logic [1:0] c);
    logic [11:0] l;
    l = ALL_RED;
    case (s)
      ST_GREEN:  l[3*c +: 3] = 3'b100;
      ST_YELLOW: l[3*c +: 3] = 3'b010;
      default:   l = ALL_RED;
    endcase
    return l;
  endfunction

  // Conflicting demand: pedestrian or any approach other than the current one.
  always_comb begin
    w_cur_mask = 4'b0001 << r_cur;
    w_demand   = r_ped_pending | (|(req & ~w_cur_mask));
  end

  // Round-robin search cur+1, cur+2, cur+3, then cur. Iterating from the
  // farthest candidate down lets the nearest requesting approach win; the
  // fallback is cur whether or not it is requesting.
  always_comb begin
    w_grant = r_cur;
    for (int unsigned k = 3; k > 0; k--) begin
      if (req[r_cur + 2'(k)]) begin
        w_grant = r_cur + 2'(k);
      end
    end
  end

  // Next-state / timer logic; only tick cycles can advance the phase.
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_ncur   = r_cur;
    if (tick) begin
      case (r_state)
        ST_GREEN: begin
          if (w_demand && (((r_cnt >= L_GMIN) && !req[r_cur]) || (r_cnt == L_GMAX))) begin
            w_nstate = ST_YELLOW;
            w_ncnt   = '0;
          end else if (r_cnt != L_GMAX) begin
            w_ncnt = r_cnt + 1'b1;
          end
        end
        ST_YELLOW: begin
          if (r_cnt == L_Y) begin
            w_nstate = ST_ALLRED;
            w_ncnt   = '0;
          end else begin
            w_ncnt = r_cnt + 1'b1;
          end
        end
        ST_ALLRED: begin
          if (r_cnt == L_AR) begin
            w_ncnt = '0;
            if (r_ped_pending) begin
              w_nstate = ST_WALK;
            end else begin
              w_nstate = ST_GREEN;
              w_ncur   = w_grant;
            end
          end else begin
            w_ncnt = r_cnt + 1'b1;
          end
        end
        ST_WALK: begin
          if (r_cnt == L_WALK) begin
            w_nstate = ST_ALLRED;
            w_ncnt   = '0;
          end else begin
            w_ncnt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_nstate = ST_ALLRED;
          w_ncnt   = '0;
        end
      endcase
    end
  end

  // Pedestrian latch: clearing on WALK entry wins over a coincident press,
  // and presses while already walking are dropped.
  always_comb begin
    w_nped = r_ped_pending;
    if ((w_nstate == ST_WALK) && (r_state != ST_WALK)) begin
      w_nped = 1'b0;
    end else if (ped_req && (r_state != ST_WALK)) begin
      w_nped = 1'b1;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_ALLRED;
      r_cnt         <= '0;
      r_cur         <= '0;
      r_ped_pending <= 1'b0;
      r_lights      <= ALL_RED;
      r_walk        <= 1'b0;
    end else begin
      r_state       <= w_nstate;
      r_cnt         <= w_ncnt;
      r_cur         <= w_ncur;
      r_ped_pending <= w_nped;
      r_lights      <= lamp_pattern(w_nstate, w_ncur);
      r_walk        <= (w_nstate == ST_WALK);
    end
  end

  assign lights = r_lights;
  assign walk   = r_walk;
  assign cur    = r_cur;

endmodule
